fir_stream_ctrl: RTL
====================

Name: fir_stream_ctrl

Overview:
- Sequencer for the moving-average FIR datapath: generates its next_dv sample strobes at a programmable decimation rate and gates its tvalid input.
- Flushes the filter history on start, restart or upstream loss, then runs a fill phase, and flags when the filter output holds a complete FIR_LEN window.
- Sits between the ADC stream and the FIR instance; out_valid and out_strobe feed downstream capture logic.

Parameters:
- FIR_LEN, 64: filter length; must match the filter's FIR_DECI.
- FIR_LEN_L, 6: log2(FIR_LEN).
- DECI_W, 16: width of the decimation setting.

Ports:
- a_clk  in  1  system clock; all logic is on its rising edge.
- a_resetn  in  1  asynchronous active-low reset.
- enable  in  1  run request (level).
- restart  in  1  single-cycle pulse; forces a re-flush.
- deci  in  DECI_W  strobe period minus 1; latched on entry to FLUSH.
- up_tvalid  in  1  upstream stream valid.
- next_dv  out  1  one-cycle strobe to the filter.
- fir_tvalid  out  1  tvalid to the filter.
- out_valid  out  1  filter window is complete (state RUN).
- out_strobe  out  1  one-cycle pulse, one cycle after each RUN-state next_dv; marks a fresh sum.
- fill_level  out  FIR_LEN_L+1  count of valid strobes since the last flush, saturating at FIR_LEN.
- state  out  2  0=IDLE, 1=FLUSH, 2=FILL, 3=RUN.

Behaviour:
- Reset (async assert, sync release): every output is 0, state is IDLE, all counters are 0, deci_l is 0.
- Strobe generator: a phase counter is cleared on every state entry. next_dv goes high for one cycle when the counter reaches P-1, then the counter wraps to 0. The first strobe occurs P cycles after state entry.
  - P = 2 in FLUSH.
  - P = deci_l+1 in FILL and RUN, where deci_l = max(deci,1) latched on FLUSH entry. Minimum period is therefore 2, which guarantees a low phase between strobes.
  - next_dv is never high in IDLE.
- fir_tvalid is registered and changes only on state entry: 0 in IDLE and FLUSH, 1 in FILL and RUN. The earliest strobe follows a change by at least 2 cycles, so fir_tvalid is stable at every next_dv rising edge.
- IDLE -> FLUSH when enable=1.
- FLUSH: issue exactly FIR_LEN strobes, which zeroes every buffer slot, the sum and data_in. fill_level is held at 0. Transition to FILL on the edge after the FIR_LEN-th strobe.
- FILL: count strobes; fill_level increments per strobe, saturating at FIR_LEN. After FIR_LEN+1 strobes go to RUN (the extra strobe covers the filter's one-sample input register). out_valid=0 throughout FILL.
- RUN: out_valid=1. out_strobe pulses one cycle after each next_dv. deci changes are ignored until the next FLUSH entry.
- Events that return to FLUSH:
  - restart=1 in FLUSH, FILL or RUN -> re-enter FLUSH: phase and strobe counters cleared, deci re-latched. restart=1 in IDLE is ignored.
  - up_tvalid=0 sampled in FILL or RUN -> FLUSH on the next edge.
  - up_tvalid is not checked in FLUSH.
- enable=0 in any state -> IDLE on the next edge. All outputs drop to 0 and fill_level clears.
- Priority on the same edge: reset > enable low > restart > up_tvalid low > normal transition.
- A strobe that coincides with a transition edge is still counted in the old state. The new state restarts its phase from 0.
- The fill_level saturation boundary is exactly FIR_LEN; the field has no wrap.
- Reset asserted mid-operation: outputs clear immediately (async), even inside a next_dv high cycle.

Test Plan:
- FIR_LEN=4, deci=3, enable raised at cycle 0 -> 4 FLUSH strobes, 2 cycles apart, with fir_tvalid=0; FILL strobes every 4 cycles; out_valid rises on the edge after the 5th FILL strobe; out_strobe lags each RUN strobe by 1 cycle.
- deci=0 -> effective period 2: next_dv alternates 1/0, never high on consecutive cycles.
- In RUN, deci changed 3->7 -> period stays 4. Then a restart pulse -> FLUSH (state=1, out_valid=0, fill_level=0), and the following FILL/RUN period is 8.
- up_tvalid dropped for 1 cycle during FILL at fill_level=2 -> next edge state=1, fir_tvalid=0, full 4-strobe flush, refill from 0.
- enable=0 and restart=1 on the same cycle in RUN -> state IDLE, next_dv stays 0, no FLUSH entry.
- a_resetn pulsed low asynchronously in the middle of a next_dv high cycle -> all outputs are 0 before the next a_clk edge; after release with enable=1, a normal FLUSH sequence starts.

Source files
------------

// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl
// Sequencer for the moving-average FIR datapath. It produces the next_dv
// sample strobes at a programmable decimation rate and gates the filter's
// tvalid input. On start, restart or loss of the upstream stream it flushes
// the filter history, then fills the window. It flags when the filter output
// holds a complete FIR_LEN window.
//
// Ports
//   a_clk       system clock, rising edge
//   a_resetn    asynchronous active-low reset
//   enable      run request (level)
//   restart     single-cycle pulse, forces a re-flush
//   deci        strobe period minus 1, latched on entry to FLUSH
//   up_tvalid   upstream stream valid
//   next_dv     one-cycle sample strobe to the filter
//   fir_tvalid  tvalid to the filter
//   out_valid   filter window complete (RUN)
//   out_strobe  one-cycle pulse one cycle after each RUN strobe
//   fill_level  valid strobes since the last flush, saturating at FIR_LEN
//   state       0=IDLE 1=FLUSH 2=FILL 3=RUN
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | disabled, all outputs low
// FLUSH | FIR_LEN strobes at period 2 with tvalid low zero the history
// FILL  | FIR_LEN+1 valid strobes at period deci_l+1 refill the window
// RUN   | window complete, out_strobe marks each fresh sum
module fir_stream_ctrl #(
    parameter int FIR_LEN   = 64,
    parameter int FIR_LEN_L = 6,
    parameter int DECI_W    = 16
) (
    input  logic                 a_clk,
    input  logic                 a_resetn,
    input  logic                 enable,
    input  logic                 restart,
    input  logic [DECI_W-1:0]    deci,
    input  logic                 up_tvalid,
    output logic                 next_dv,
    output logic                 fir_tvalid,
    output logic                 out_valid,
    output logic                 out_strobe,
    output logic [FIR_LEN_L:0]   fill_level,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_FILL  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [FIR_LEN_L:0] CNT_ONE    = (FIR_LEN_L+1)'(1);
    localparam logic [FIR_LEN_L:0] FLUSH_LAST = (FIR_LEN_L+1)'(FIR_LEN - 1);
    // FILL takes one extra strobe to push through the filter's input register
    localparam logic [FIR_LEN_L:0] FILL_LAST  = (FIR_LEN_L+1)'(FIR_LEN);
    localparam logic [FIR_LEN_L:0] FILL_MAX   = (FIR_LEN_L+1)'(FIR_LEN);
    localparam logic [DECI_W-1:0]  PH_ONE     = DECI_W'(1);

    state_t             state_q, state_d;
    logic [DECI_W-1:0]  phase_q, phase_d;
    logic [DECI_W-1:0]  deci_l_q, deci_l_d;
    logic [DECI_W-1:0]  phase_last;
    logic [FIR_LEN_L:0] scnt_q, scnt_d;
    logic [FIR_LEN_L:0] fill_q, fill_d;
    logic               tvalid_q, tvalid_d;
    logic               ostb_q, ostb_d;
    logic               entry;
    logic               strobe;

    // Strobe is a decode of registered state, so an async reset removes it at once
    always_comb begin
        phase_last = (state_q == S_FLUSH) ? PH_ONE : deci_l_q;
        strobe     = (state_q != S_IDLE) && (phase_q == phase_last);
    end

    always_comb begin
        state_d = state_q;
        entry   = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            state_d = S_FLUSH;
        end else if (restart) begin
            state_d = S_FLUSH;
            entry   = 1'b1;
        end else if (!up_tvalid && (state_q == S_FILL || state_q == S_RUN)) begin
            state_d = S_FLUSH;
        end else if (state_q == S_FLUSH && strobe && scnt_q == FLUSH_LAST) begin
            state_d = S_FILL;
        end else if (state_q == S_FILL && strobe && scnt_q == FILL_LAST) begin
            state_d = S_RUN;
        end
        if (state_d != state_q) begin
            entry = 1'b1;
        end
    end

    always_comb begin
        phase_d = phase_q + PH_ONE;
        if (entry || strobe || state_d == S_IDLE) begin
            phase_d = '0;
        end

        scnt_d = scnt_q;
        if (entry || state_d == S_IDLE) begin
            scnt_d = '0;
        end else if (strobe && (state_q == S_FLUSH || state_q == S_FILL)) begin
            scnt_d = scnt_q + CNT_ONE;
        end

        fill_d = fill_q;
        if (state_d == S_IDLE || state_d == S_FLUSH) begin
            fill_d = '0;
        end else if (strobe && (state_q == S_FILL || state_q == S_RUN) && fill_q != FILL_MAX) begin
            fill_d = fill_q + CNT_ONE;
        end

        deci_l_d = deci_l_q;
        if (entry && state_d == S_FLUSH) begin
            deci_l_d = (deci == '0) ? PH_ONE : deci;
        end

        tvalid_d = (state_d == S_FILL) || (state_d == S_RUN);
        // A strobe on the edge that leaves RUN produces no fresh-sum pulse
        ostb_d   = strobe && (state_q == S_RUN) && (state_d == S_RUN);
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            deci_l_q <= '0;
            scnt_q   <= '0;
            fill_q   <= '0;
            tvalid_q <= 1'b0;
            ostb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            deci_l_q <= deci_l_d;
            scnt_q   <= scnt_d;
            fill_q   <= fill_d;
            tvalid_q <= tvalid_d;
            ostb_q   <= ostb_d;
        end
    end

    assign next_dv    = strobe;
    assign fir_tvalid = tvalid_q;
    assign out_valid  = (state_q == S_RUN);
    assign out_strobe = ostb_q;
    assign fill_level = fill_q;
    assign state      = state_q;

endmodule
